sub_int8_serial: RTL and testbench

//   Bit-serial 8-bit integer subtractor; the inverse-direction companion of the

---
 rtl/sub_int8_serial_if.sv | 27 ++
 rtl/sub_int8_serial.sv | 144 ++++++++++++++
 tb/tb_sub_int8_serial.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sub_int8_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor and the master side is whatever feeds and drains it.
`timescale 1ns/1ps

interface sub_int8_serial_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Borrow_out;
    logic             Ovf;

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Diff, Borrow_out, Ovf
    );

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Diff, Borrow_out, Ovf
    );
endinterface

// File: rtl/sub_int8_serial.sv
// Bit-serial subtractor: computes A - B LSB first through one full-subtractor
// cell and a borrow flop, with one operation in flight behind valid/ready.
`timescale 1ns/1ps

module sub_int8_serial #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sub_int8_serial_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             bw_q,     bw_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;

    logic cell_a;
    logic cell_b;
    logic cell_bi;
    logic cell_d;
    logic cell_bo;
    logic cnt_last;

    assign cell_a   = a_q[0];
    assign cell_b   = b_q[0];
    assign cell_bi  = bw_q;
    assign cnt_last = (cnt_q == CNT_LAST);

    generate
        if (IMPL_TYPE == 0) begin : g_xor_cell
            assign cell_d  = cell_a ^ cell_b ^ cell_bi;
            assign cell_bo = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & cell_bi);
        end else begin : g_nand_cell
            // Nine-NAND full subtractor; n3 = ~(~a & b) and n7 = ~(~(a^b) & bi).
            logic n1, n2, n3, x_ab, n5, n6, n7;
            assign n1      = ~(cell_a & cell_b);
            assign n2      = ~(cell_a & n1);
            assign n3      = ~(cell_b & n1);
            assign x_ab    = ~(n2 & n3);
            assign n5      = ~(x_ab & cell_bi);
            assign n6      = ~(x_ab & n5);
            assign n7      = ~(cell_bi & n5);
            assign cell_d  = ~(n6 & n7);
            assign cell_bo = ~(n3 & n7);
        end
    endgenerate

    // NOTE: every signal gets a default before the case so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                bw_d   = cell_bo;
                if (cnt_last) begin
                    // On the last bit the cell inputs are the operand MSBs and cell_d is Diff's MSB.
                    cnt_d    = '0;
                    borrow_d = cell_bo;
                    ovf_d    = (cell_a ^ cell_b) & (cell_a ^ cell_d);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.Diff       = diff_q;
    assign bus.Borrow_out = borrow_q;
    assign bus.Ovf        = ovf_q;

    cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_sub_int8_serial.sv
// Drives both subtractor cell forms with identical traffic and checks each
// against plain-arithmetic A - B, including latency, backpressure and reset.
`timescale 1ns/1ps

module tb_sub_int8_serial;

    localparam int W      = 8;
    localparam int N_RAND = 1500;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sub_int8_serial_if #(.WIDTH(W)) bus0 ();
    sub_int8_serial_if #(.WIDTH(W)) bus1 ();

    sub_int8_serial #(.WIDTH(W), .IMPL_TYPE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    sub_int8_serial #(.WIDTH(W), .IMPL_TYPE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        bus0.in_valid = v;  bus0.A = a;  bus0.B = b;
        bus1.in_valid = v;  bus1.A = a;  bus1.B = b;
    endtask

    task automatic drive_ready(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    // Reference: {ovf, borrow, diff} from integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, sa, sb, sd;
        logic [W-1:0] diff;
        logic borrow, ovf;
        ua     = int'(a);
        ub     = int'(b);
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        sd     = sa - sb;
        diff   = W'(ua - ub + (1 << W));
        borrow = (ua < ub);
        ovf    = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        return {ovf, borrow, diff};
    endfunction

    task automatic check_outputs(input string tag, input logic vld, input logic [W+1:0] exp);
        check({tag, ".d0.valid"},  32'(bus0.out_valid),  32'(vld));
        check({tag, ".d1.valid"},  32'(bus1.out_valid),  32'(vld));
        check({tag, ".d0.ready"},  32'(bus0.in_ready),   32'(!vld));
        check({tag, ".d1.ready"},  32'(bus1.in_ready),   32'(!vld));
        check({tag, ".d0.diff"},   32'(bus0.Diff),       32'(exp[W-1:0]));
        check({tag, ".d1.diff"},   32'(bus1.Diff),       32'(exp[W-1:0]));
        check({tag, ".d0.borrow"}, 32'(bus0.Borrow_out), 32'(exp[W]));
        check({tag, ".d1.borrow"}, 32'(bus1.Borrow_out), 32'(exp[W]));
        check({tag, ".d0.ovf"},    32'(bus0.Ovf),        32'(exp[W+1]));
        check({tag, ".d1.ovf"},    32'(bus1.Ovf),        32'(exp[W+1]));
    endtask

    // Called at a negedge with both DUTs idle; returns at a negedge, idle again.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit noise);
        int lat;
        logic [W+1:0] exp;
        exp = model(a, b);
        check({tag, ".d0.accept_rdy"}, 32'(bus0.in_ready), 32'd1);
        check({tag, ".d1.accept_rdy"}, 32'(bus1.in_ready), 32'd1);
        drive_in(1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, W'($urandom), W'($urandom));
        lat = 0;
        while (!bus0.out_valid && lat < 4 * W) begin
            if (noise) drive_in(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        drive_in(1'b0, W'($urandom), W'($urandom));
        check({tag, ".latency"}, 32'(lat), 32'(W));
        if (!bus0.out_valid) return;
        for (int s = 0; s <= stall; s++) begin
            check_outputs({tag, ".hold"}, 1'b1, exp);
            if (s < stall) begin
                if (noise) drive_in(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
                @(posedge clk);
                @(negedge clk);
            end
        end
        drive_in(1'b0, W'($urandom), W'($urandom));
        drive_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_ready(1'b0);
        check({tag, ".d0.released"}, 32'(bus0.out_valid), 32'd0);
        check({tag, ".d1.released"}, 32'(bus1.out_valid), 32'd0);
        check({tag, ".d0.idle"},     32'(bus0.in_ready),  32'd1);
        check({tag, ".d1.idle"},     32'(bus1.in_ready),  32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int n;

        rst_n = 1'b0;
        drive_in(1'b0, '0, '0);
        drive_ready(1'b0);
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("post_reset", 1'b0, '0);

        run_op("sub_100_58", 8'd100, 8'd58, 0, 0);
        run_op("wrap_0_1",   8'd0,   8'd1,  0, 0);
        run_op("ovf_80_01",  8'h80,  8'h01, 0, 0);
        run_op("ovf_7f_ff",  8'h7F,  8'hFF, 0, 0);
        run_op("backpress",  8'd100, 8'd58, 20, 1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("no_queued.d0.valid", 32'(bus0.out_valid), 32'd0);
            check("no_queued.d1.valid", 32'(bus1.out_valid), 32'd0);
        end

        // Reset in the third RUN cycle of an op whose partial Diff bits are ones.
        drive_in(1'b1, 8'hFF, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs("rst_mid_run", 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst_5_7", 8'd5, 8'd7, 0, 0);

        // Reset while a result is waiting in DONE.
        drive_in(1'b1, 8'hFF, 8'h01);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, '0, '0);
        n = 0;
        while (!bus0.out_valid && n < 4 * W) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("rst_done.latency", 32'(n), 32'(W));
        check_outputs("pre_rst_done", 1'b1, model(8'hFF, 8'h01));
        rst_n = 1'b0;
        #1 check_outputs("rst_mid_done", 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < N_RAND; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                @(negedge clk);
            end
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 8'h00;
                1: ra = 8'h80;
                2: rb = 8'h7F;
                3: rb = 8'hFF;
                default: ;
            endcase
            run_op("rand", ra, rb, $urandom_range(0, 4), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog expired");
    end

endmodule
